// File: rtl/serial_parity_gen_if.sv
// Handshake bundle for serial_parity_gen.
//   in_valid / in_bit / in_ready     : serial bit stream into the generator
//   out_valid / out_parity / out_ready: one parity bit per completed frame
//   bit_cnt                          : bits accepted so far in the current frame
// The slave modport is the generator's view; master is the stream/sink side.
interface serial_parity_gen_if #(
  parameter int FRAME_LEN = 8
);
  localparam int CW = $clog2(FRAME_LEN);

  logic          in_valid;
  logic          in_bit;
  logic          in_ready;
  logic          out_valid;
  logic          out_parity;
  logic          out_ready;
  logic [CW-1:0] bit_cnt;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_parity, bit_cnt
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_parity, bit_cnt
  );
endinterface

// File: rtl/serial_parity_gen.sv
// Serial parity generator: XOR-folds one bit per accepted beat and emits one
// parity bit per frame of FRAME_LEN bits, with valid/ready on both sides.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - synchronous active-low reset; overrides clr and both handshakes
//   clr    - synchronous frame abort (ignored while a parity bit is held)
//   bus    - serial_parity_gen_if.slave: in_valid/in_bit/in_ready,
//            out_valid/out_parity/out_ready, bit_cnt
// Parameters:
//   FRAME_LEN - data bits per frame (2..256)
//   ODD       - 0: even parity (XOR of bits), 1: odd parity (inverted XOR)
module serial_parity_gen #(
  parameter int FRAME_LEN = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  serial_parity_gen_if.slave        bus
);
  localparam int          CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          acc, acc_nxt;
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  logic          out_valid, out_valid_nxt;
  logic          out_parity, out_parity_nxt;
  logic          in_xfer, out_xfer;

  // in_ready depends only on registered state, so there is no combinational
  // path from out_ready or in_valid back to in_ready.
  assign bus.in_ready   = (state != HOLD);
  assign in_xfer        = bus.in_valid & bus.in_ready;
  assign out_xfer       = out_valid & bus.out_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_parity = out_parity;
  assign bus.bit_cnt    = bit_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= 1'b0;
      bit_cnt    <= '0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      bit_cnt    <= bit_cnt_nxt;
      out_valid  <= out_valid_nxt;
      out_parity <= out_parity_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    bit_cnt_nxt    = bit_cnt;
    out_valid_nxt  = out_valid;
    out_parity_nxt = out_parity;

    unique case (state)
      IDLE: begin
        // An abort in IDLE wins over a same-cycle beat: the beat is dropped.
        if (clr) begin
          acc_nxt     = 1'b0;
          bit_cnt_nxt = '0;
        end else if (in_xfer) begin
          acc_nxt     = bus.in_bit;
          bit_cnt_nxt = CW'(1);
          state_nxt   = ACCUM;
        end
      end

      ACCUM: begin
        if (clr) begin
          acc_nxt     = 1'b0;
          bit_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else if (in_xfer) begin
          if (bit_cnt == LAST) begin
            out_parity_nxt = acc ^ bus.in_bit ^ ODD;
            out_valid_nxt  = 1'b1;
            acc_nxt        = 1'b0;
            bit_cnt_nxt    = '0;
            state_nxt      = HOLD;
          end else begin
            acc_nxt     = acc ^ bus.in_bit;
            bit_cnt_nxt = bit_cnt + CW'(1);
          end
        end
      end

      HOLD: begin
        // clr is deliberately ignored here so a finished parity bit survives.
        if (out_xfer) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end
endmodule
